// File: rtl/mcu_pkg.sv
// Shared encodings for the multicycle control unit: states, opcodes and datapath mux selects.
package mcu_pkg;

    typedef enum logic [3:0] {
        StFetch   = 4'd0,
        StDecode  = 4'd1,
        StMemAddr = 4'd2,
        StMemRd   = 4'd3,
        StMemWb   = 4'd4,
        StMemWr   = 4'd5,
        StExecR   = 4'd6,
        StRWb     = 4'd7,
        StBranch  = 4'd8,
        StJump    = 4'd9,
        StAddiEx  = 4'd10,
        StAddiWb  = 4'd11,
        StTrap    = 4'd12
    } state_e;

    localparam logic [5:0] OpRType = 6'h00;
    localparam logic [5:0] OpLw    = 6'h23;
    localparam logic [5:0] OpSw    = 6'h2B;
    localparam logic [5:0] OpBeq   = 6'h04;
    localparam logic [5:0] OpJ     = 6'h02;
    localparam logic [5:0] OpAddi  = 6'h08;

    localparam logic [1:0] AluAdd   = 2'd0;
    localparam logic [1:0] AluSub   = 2'd1;
    localparam logic [1:0] AluRType = 2'd2;

    localparam logic [1:0] SrcBRegB   = 2'd0;
    localparam logic [1:0] SrcBFour   = 2'd1;
    localparam logic [1:0] SrcBImm    = 2'd2;
    localparam logic [1:0] SrcBImmSh2 = 2'd3;

    localparam logic [1:0] PcSrcAlu    = 2'd0;
    localparam logic [1:0] PcSrcAluOut = 2'd1;
    localparam logic [1:0] PcSrcJump   = 2'd2;

    function automatic state_e decode_next(input logic [5:0] op);
        case (op)
            OpRType:    return StExecR;
            OpLw, OpSw: return StMemAddr;
            OpBeq:      return StBranch;
            OpJ:        return StJump;
            OpAddi:     return StAddiEx;
            default:    return StTrap;
        endcase
    endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Counts consecutive not-ready cycles in a memory-wait state and flags the final allowed cycle.
module mem_wait_timer #(
    parameter int unsigned MEM_TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic waiting,
    input  logic mem_ready,
    output logic expired
);

    logic [7:0] count_q;

    // Any cycle that is not a stalled wait leaves or avoids a wait state, so clearing here
    // guarantees a zero count on every entry.
    always_ff @(posedge clk) begin
        if (rst || !waiting || mem_ready) begin
            count_q <= '0;
        end else begin
            count_q <= count_q + 8'd1;
        end
    end

    assign expired = waiting && !mem_ready && (count_q == 8'(MEM_TIMEOUT - 1));

endmodule

// File: rtl/multicycle_control_unit.sv
// Multicycle MIPS-style control FSM with memory-wait timeout and illegal-opcode trap.
module multicycle_control_unit
    import mcu_pkg::*;
#(
    parameter int unsigned OPCODE_W    = 6,
    parameter int unsigned ALU_OP_W    = 2,
    parameter int unsigned MEM_TIMEOUT = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [OPCODE_W-1:0] opcode,
    input  logic                zero,
    input  logic                mem_ready,
    output logic                mem_read,
    output logic                mem_write,
    output logic                iord,
    output logic                ir_write,
    output logic                pc_write,
    output logic                reg_write,
    output logic                reg_dst,
    output logic                mem_2_reg,
    output logic                alu_src_a,
    output logic [1:0]          alu_src_b,
    output logic [ALU_OP_W-1:0] alu_op,
    output logic [1:0]          pc_source,
    output logic [3:0]          state_o,
    output logic                illegal,
    output logic                timeout
);

    state_e     state_q, state_d;
    logic       illegal_q, timeout_q;
    logic       set_illegal, set_timeout;
    logic       waiting, expired;
    logic       op_fits;
    logic [5:0] op_low;
    logic [1:0] alu_op_sel;

    // Opcodes wider than the known set only match if the extra upper bits are zero.
    assign op_fits = (opcode >> 6) == '0;
    assign op_low  = 6'(opcode);
    assign waiting = (state_q == StFetch) || (state_q == StMemRd) || (state_q == StMemWr);

    mem_wait_timer #(
        .MEM_TIMEOUT(MEM_TIMEOUT)
    ) u_wait_timer (
        .clk      (clk),
        .rst      (rst),
        .waiting  (waiting),
        .mem_ready(mem_ready),
        .expired  (expired)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StFetch;
            illegal_q <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            illegal_q <= illegal_q | set_illegal;
            timeout_q <= timeout_q | set_timeout;
        end
    end

    always_comb begin
        state_d     = state_q;
        set_illegal = 1'b0;
        set_timeout = 1'b0;
        mem_read    = 1'b0;
        mem_write   = 1'b0;
        iord        = 1'b0;
        ir_write    = 1'b0;
        pc_write    = 1'b0;
        reg_write   = 1'b0;
        reg_dst     = 1'b0;
        mem_2_reg   = 1'b0;
        alu_src_a   = 1'b0;
        alu_src_b   = SrcBRegB;
        alu_op_sel  = AluAdd;
        pc_source   = PcSrcAlu;

        case (state_q)
            StFetch: begin
                mem_read  = 1'b1;
                alu_src_b = SrcBFour;
                ir_write  = mem_ready;
                pc_write  = mem_ready;
                if (mem_ready) begin
                    state_d = StDecode;
                end else if (expired) begin
                    state_d     = StTrap;
                    set_timeout = 1'b1;
                end
            end
            StDecode: begin
                alu_src_b = SrcBImmSh2;
                state_d   = op_fits ? decode_next(op_low) : StTrap;
                if (state_d == StTrap) begin
                    set_illegal = 1'b1;
                end
            end
            StMemAddr: begin
                alu_src_a = 1'b1;
                alu_src_b = SrcBImm;
                state_d   = (op_fits && op_low == OpSw) ? StMemWr : StMemRd;
            end
            StMemRd, StMemWr: begin
                mem_read  = (state_q == StMemRd);
                mem_write = (state_q == StMemWr);
                iord      = 1'b1;
                if (mem_ready) begin
                    state_d = (state_q == StMemRd) ? StMemWb : StFetch;
                end else if (expired) begin
                    state_d     = StTrap;
                    set_timeout = 1'b1;
                end
            end
            StMemWb: begin
                reg_write = 1'b1;
                mem_2_reg = 1'b1;
                state_d   = StFetch;
            end
            StExecR: begin
                alu_src_a  = 1'b1;
                alu_op_sel = AluRType;
                state_d    = StRWb;
            end
            StRWb: begin
                reg_write = 1'b1;
                reg_dst   = 1'b1;
                state_d   = StFetch;
            end
            StBranch: begin
                alu_src_a  = 1'b1;
                alu_op_sel = AluSub;
                pc_source  = PcSrcAluOut;
                pc_write   = zero;
                state_d    = StFetch;
            end
            StJump: begin
                pc_source = PcSrcJump;
                pc_write  = 1'b1;
                state_d   = StFetch;
            end
            StAddiEx: begin
                alu_src_a = 1'b1;
                alu_src_b = SrcBImm;
                state_d   = StAddiWb;
            end
            StAddiWb: begin
                reg_write = 1'b1;
                state_d   = StFetch;
            end
            StTrap: state_d = StTrap;
            default: state_d = StFetch;
        endcase

        // Architectural side effects must not fire while reset is held.
        if (rst) begin
            mem_write = 1'b0;
            reg_write = 1'b0;
            pc_write  = 1'b0;
            ir_write  = 1'b0;
        end
    end

    assign alu_op  = ALU_OP_W'(alu_op_sel);
    assign state_o = state_q;
    assign illegal = illegal_q;
    assign timeout = timeout_q;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Self-checking bench: per-cycle comparison against a table-driven model plus directed literal checks.
module tb_multicycle_control_unit;

    localparam int TO = 4;

    logic       clk = 1'b0;
    logic       rst, zero, mem_ready;
    logic [5:0] opcode;
    logic       mem_read, mem_write, iord, ir_write, pc_write, reg_write;
    logic       reg_dst, mem_2_reg, alu_src_a;
    logic [1:0] alu_src_b, alu_op, pc_source;
    logic [3:0] state_o;
    logic       illegal, timeout;

    int n_cmp  = 0;
    int n_fail = 0;

    multicycle_control_unit #(
        .OPCODE_W   (6),
        .ALU_OP_W   (2),
        .MEM_TIMEOUT(TO)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .opcode   (opcode),
        .zero     (zero),
        .mem_ready(mem_ready),
        .mem_read (mem_read),
        .mem_write(mem_write),
        .iord     (iord),
        .ir_write (ir_write),
        .pc_write (pc_write),
        .reg_write(reg_write),
        .reg_dst  (reg_dst),
        .mem_2_reg(mem_2_reg),
        .alu_src_a(alu_src_a),
        .alu_src_b(alu_src_b),
        .alu_op   (alu_op),
        .pc_source(pc_source),
        .state_o  (state_o),
        .illegal  (illegal),
        .timeout  (timeout)
    );

    always #5 clk = ~clk;

    // Row layout: rd wr iord irw pcw rw rdst m2r srca | srcb | aluop | pcsrc
    logic [14:0] rows [0:12] = '{
        15'b100000000_01_00_00,  // fetch
        15'b000000000_11_00_00,  // decode
        15'b000000001_10_00_00,  // mem addr
        15'b101000000_00_00_00,  // mem rd
        15'b000001010_00_00_00,  // mem wb
        15'b011000000_00_00_00,  // mem wr
        15'b000000001_00_10_00,  // exec r
        15'b000001100_00_00_00,  // r wb
        15'b000000001_00_01_01,  // branch
        15'b000010000_00_00_10,  // jump
        15'b000000001_10_00_00,  // addi ex
        15'b000001000_00_00_00,  // addi wb
        15'b000000000_00_00_00   // trap
    };
    int follow [0:12] = '{0, 0, 0, 0, 0, 0, 7, 0, 0, 0, 11, 0, 12};
    int dec_map [int];

    int m_state = 0;
    int m_wait  = 0;
    bit m_ill   = 1'b0;
    bit m_to    = 1'b0;
    bit m_valid = 1'b0;

    initial begin
        dec_map[32'h00] = 6;
        dec_map[32'h23] = 2;
        dec_map[32'h2B] = 2;
        dec_map[32'h04] = 8;
        dec_map[32'h02] = 9;
        dec_map[32'h08] = 10;
    end

    always @(posedge clk) begin : model
        int prev;
        if (rst) begin
            m_state = 0;
            m_wait  = 0;
            m_ill   = 1'b0;
            m_to    = 1'b0;
            m_valid = 1'b1;
        end else if (m_valid) begin
            prev = m_state;
            if (m_state == 0 || m_state == 3 || m_state == 5) begin
                if (mem_ready) begin
                    m_state = (m_state == 0) ? 1 : (m_state == 3) ? 4 : 0;
                end else if (m_wait == TO - 1) begin
                    m_state = 12;
                    m_to    = 1'b1;
                end else begin
                    m_wait++;
                end
            end else if (m_state == 1) begin
                if (dec_map.exists(int'(opcode))) begin
                    m_state = dec_map[int'(opcode)];
                end else begin
                    m_state = 12;
                    m_ill   = 1'b1;
                end
            end else if (m_state == 2) begin
                m_state = (opcode == 6'h2B) ? 5 : 3;
            end else begin
                m_state = follow[m_state];
            end
            if (m_state != prev) m_wait = 0;
        end
    end

    logic       e_rd, e_wr, e_iord, e_irw, e_pcw, e_rw, e_rdst, e_m2r, e_srca;
    logic [1:0] e_srcb, e_aluop, e_pcsrc;
    logic [20:0] exp_vec, act_vec;

    always @(negedge clk) begin
        if (m_valid) begin
            {e_rd, e_wr, e_iord, e_irw, e_pcw, e_rw, e_rdst, e_m2r, e_srca,
             e_srcb, e_aluop, e_pcsrc} = rows[m_state];
            if (m_state == 0) begin
                e_irw = mem_ready;
                e_pcw = mem_ready;
            end
            if (m_state == 8) e_pcw = zero;
            if (rst) {e_wr, e_irw, e_pcw, e_rw} = 4'b0;
            exp_vec = {e_rd, e_wr, e_iord, e_irw, e_pcw, e_rw, e_rdst, e_m2r, e_srca,
                       e_srcb, e_aluop, e_pcsrc, 4'(m_state), m_ill, m_to};
            act_vec = {mem_read, mem_write, iord, ir_write, pc_write, reg_write, reg_dst,
                       mem_2_reg, alu_src_a, alu_src_b, alu_op, pc_source, state_o,
                       illegal, timeout};
            n_cmp++;
            if (act_vec !== exp_vec) begin
                n_fail++;
                $display("FAIL cycle_model t=%0t: got %b required %b", $time, act_vec, exp_vec);
            end
        end
    end

    task automatic check_lit(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s t=%0t: got %0h required %0h", name, $time, act, req);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Starts in a FETCH cycle and ends at the start of the next FETCH cycle.
    task automatic measure(input logic [5:0] op, input int req, input string name);
        int cyc;
        opcode    = op;
        mem_ready = 1'b1;
        cyc = 1;
        step();
        while (state_o != 4'd0 && cyc < 20) begin
            cyc++;
            step();
        end
        check_lit(name, cyc, req);
    endtask

    int lw_states [0:4] = '{0, 1, 2, 3, 4};
    int wr_cnt;
    logic rw_seen;

    initial begin
        rst       = 1'b1;
        opcode    = 6'h00;
        zero      = 1'b0;
        mem_ready = 1'b1;
        step();
        step();
        @(negedge clk);
        check_lit("reset_state", state_o, 0);
        check_lit("reset_strobes", {ir_write, pc_write, mem_write, reg_write}, 0);
        check_lit("reset_flags", {illegal, timeout}, 0);
        step();
        rst    = 1'b0;
        opcode = 6'h23;

        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check_lit("lw_state_seq", state_o, lw_states[i]);
            check_lit("lw_writeback", {reg_write, mem_2_reg}, (i == 4) ? 2'b11 : 2'b00);
            step();
        end
        check_lit("lw_back_to_fetch", state_o, 0);

        measure(6'h23, 5, "lat_lw");
        measure(6'h2B, 4, "lat_sw");
        measure(6'h00, 4, "lat_rtype");
        measure(6'h08, 4, "lat_addi");
        measure(6'h04, 3, "lat_beq");
        measure(6'h02, 3, "lat_j");

        opcode = 6'h04;
        zero   = 1'b1;
        step();
        step();
        @(negedge clk);
        check_lit("beq_taken", {pc_write, pc_source}, 3'b101);
        step();
        zero = 1'b0;
        step();
        step();
        @(negedge clk);
        check_lit("beq_not_taken", pc_write, 0);
        step();

        opcode = 6'h2B;
        step();
        step();
        step();
        mem_ready = 1'b0;
        wr_cnt    = 0;
        rw_seen   = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (mem_write) wr_cnt++;
            rw_seen = rw_seen | reg_write;
            step();
            if (i == 0) opcode = 6'h00;
            if (i == 2) mem_ready = 1'b1;
        end
        check_lit("sw_write_cycles", wr_cnt, 4);
        check_lit("sw_no_regwrite", rw_seen, 0);
        check_lit("sw_to_fetch", state_o, 0);

        opcode = 6'h23;
        step();
        step();
        step();
        mem_ready = 1'b0;
        step();
        step();
        mem_ready = 1'b1;
        step();
        check_lit("lw_wait_to_wb", state_o, 4);
        step();

        opcode = 6'h3F;
        step();
        step();
        @(negedge clk);
        check_lit("illegal_trap", {state_o, illegal, timeout}, {4'd12, 2'b10});
        step();
        mem_ready = 1'b0;
        opcode    = 6'h23;
        step();
        mem_ready = 1'b1;
        step();
        @(negedge clk);
        check_lit("trap_sticky", {state_o, illegal, mem_read, ir_write, pc_write},
                  {4'd12, 4'b1000});
        step();
        rst = 1'b1;
        step();
        @(negedge clk);
        check_lit("trap_reset", {state_o, illegal}, 0);
        step();
        rst       = 1'b0;
        mem_ready = 1'b0;
        step();
        step();
        step();
        @(negedge clk);
        check_lit("timeout_not_yet", state_o, 0);
        step();
        @(negedge clk);
        check_lit("timeout_trap", {state_o, timeout}, {4'd12, 1'b1});
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        step();
        step();
        step();
        mem_ready = 1'b1;
        step();
        @(negedge clk);
        check_lit("ready_wins_last_cycle", {state_o, timeout}, {4'd1, 1'b0});
        step();
        rst = 1'b1;
        step();
        rst    = 1'b0;
        opcode = 6'h2B;
        step();
        step();
        step();
        mem_ready = 1'b0;
        @(negedge clk);
        check_lit("memwr_active", {state_o, mem_write}, {4'd5, 1'b1});
        step();
        rst = 1'b1;
        #1;
        check_lit("rst_gates_memwrite", mem_write, 0);
        step();
        @(negedge clk);
        check_lit("rst_from_memwr", {state_o, mem_write}, 0);
        step();
        rst       = 1'b0;
        mem_ready = 1'b1;
        step();
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1);
    end

endmodule
